// File: rtl/io_bus_responder.sv
// IO_BUS peripheral responder: LED/switch/7-seg/cycle-counter registers behind a byte-addressed
// CPU bus, with a debounced button capturing switches and a timed hold on display updates.
module io_bus_responder #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SEG_HOLD_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  input  logic        io_rd,
  output logic [31:0] io_din,
  input  logic [15:0] sw,
  input  logic        btn,
  output logic [15:0] led,
  output logic [31:0] seg_data,
  output logic        seg_rdy
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (SEG_HOLD_CYCLES > 1) ? $clog2(SEG_HOLD_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SEG_HOLD_CYCLES - 1);

  localparam logic [7:0] ADDR_LED     = 8'h00;
  localparam logic [7:0] ADDR_SW      = 8'h04;
  localparam logic [7:0] ADDR_SEG_RDY = 8'h08;
  localparam logic [7:0] ADDR_SEG     = 8'h0C;
  localparam logic [7:0] ADDR_SWX_VLD = 8'h10;
  localparam logic [7:0] ADDR_SWX     = 8'h14;
  localparam logic [7:0] ADDR_CNT     = 8'h18;

  typedef enum logic {SEG_READY, SEG_HOLD} seg_state_t;

  logic [15:0]       sw_meta, sw_sync;
  logic              btn_meta, btn_sync;
  logic              btn_db, btn_db_d, btn_rise;
  logic [DB_W-1:0]   db_cnt;
  logic              swx_vld;
  logic [15:0]       swx_data;
  seg_state_t        seg_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [31:0]       cnt_data;
  logic              wr_led, wr_seg, rd_swx;

  assign wr_led = io_we && (io_addr == ADDR_LED);
  assign wr_seg = io_we && (io_addr == ADDR_SEG);
  assign rd_swx = io_rd && (io_addr == ADDR_SWX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

  // The debounced level only flips after btn_sync has disagreed with it for DEBOUNCE_CYCLES in a row.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
    end else begin
      btn_db_d <= btn_db;
      if (btn_sync == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= ~btn_db;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign btn_rise = btn_db & ~btn_db_d;

  // Handshakes: swx_vld is the valid flag and a read of 0x14 is the consuming ready; a capture
  // coinciding with that read wins. seg_rdy is the ready flag and a 0x0C write is the valid; a
  // write while seg_rdy=0 is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      swx_vld  <= 1'b0;
      swx_data <= '0;
    end else if (btn_rise && (!swx_vld || rd_swx)) begin
      swx_vld  <= 1'b1;
      swx_data <= sw_sync;
    end else if (rd_swx) begin
      swx_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg_state <= SEG_READY;
      seg_rdy   <= 1'b1;
      seg_data  <= '0;
      hold_cnt  <= '0;
    end else begin
      case (seg_state)
        SEG_READY: begin
          if (wr_seg) begin
            seg_data  <= io_dout;
            hold_cnt  <= HOLD_LOAD;
            seg_state <= SEG_HOLD;
            seg_rdy   <= 1'b0;
          end
        end
        SEG_HOLD: begin
          if (hold_cnt == '0) begin
            seg_state <= SEG_READY;
            seg_rdy   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led <= '0;
    end else if (wr_led) begin
      led <= io_dout[15:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_data <= '0;
    end else begin
      cnt_data <= cnt_data + 32'd1;
    end
  end

  // Read data reflects register values before the edge that applies any read side effect.
  always_comb begin
    io_din = '0;
    if (io_rd) begin
      case (io_addr)
        ADDR_SW:      io_din = {16'b0, sw_sync};
        ADDR_SEG_RDY: io_din = {31'b0, seg_rdy};
        ADDR_SWX_VLD: io_din = {31'b0, swx_vld};
        ADDR_SWX:     io_din = {16'b0, swx_data};
        ADDR_CNT:     io_din = cnt_data;
        default:      io_din = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_responder.sv
// Bench for io_bus_responder: directed scenarios plus random bus traffic, all checked against a
// cycle-level behavioural model of the register map, debouncer and display hold.
module tb_io_bus_responder;

  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic        clk, rstn;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we, io_rd;
  logic [31:0] io_din;
  logic [15:0] sw;
  logic        btn;
  logic [15:0] led;
  logic [31:0] seg_data;
  logic        seg_rdy;

  int checks = 0;
  int passes = 0;

  io_bus_responder #(.DEBOUNCE_CYCLES(DEB), .SEG_HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rstn(rstn), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we),
    .io_rd(io_rd), .io_din(io_din), .sw(sw), .btn(btn), .led(led),
    .seg_data(seg_data), .seg_rdy(seg_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  logic [15:0] m_led, m_sw_pipe[2], m_swx_data;
  logic        m_btn_pipe[2], m_db, m_db_prev, m_swx_vld, m_rise_now, m_rd14;
  logic [31:0] m_seg_data, m_cnt;
  int          m_low_left, m_run;
  logic        m_cnt_force;
  logic        m_rdy;

  assign m_rdy = (m_low_left == 0);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_led = '0; m_sw_pipe[0] = '0; m_sw_pipe[1] = '0; m_swx_data = '0;
      m_btn_pipe[0] = 1'b0; m_btn_pipe[1] = 1'b0; m_db = 1'b0; m_db_prev = 1'b0;
      m_swx_vld = 1'b0; m_seg_data = '0; m_cnt = '0; m_low_left = 0; m_run = 0;
    end else begin
      m_rise_now = m_db && !m_db_prev;
      m_rd14 = io_rd && (io_addr == 8'h14);
      if (m_rise_now && (!m_swx_vld || m_rd14)) begin
        m_swx_data = m_sw_pipe[1];
        m_swx_vld  = 1'b1;
      end else if (m_rd14) begin
        m_swx_vld = 1'b0;
      end
      if (m_low_left > 0) m_low_left = m_low_left - 1;
      else if (io_we && io_addr == 8'h0C) begin
        m_seg_data = io_dout;
        m_low_left = HOLD;
      end
      if (io_we && io_addr == 8'h00) m_led = io_dout[15:0];
      m_db_prev = m_db;
      if (m_btn_pipe[1] != m_db) begin
        m_run = m_run + 1;
        if (m_run == DEB) begin
          m_db  = !m_db;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_sw_pipe[1]  = m_sw_pipe[0];
      m_sw_pipe[0]  = sw;
      m_btn_pipe[1] = m_btn_pipe[0];
      m_btn_pipe[0] = btn;
      m_cnt = (m_cnt_force ? 32'hFFFF_FFFF : m_cnt) + 32'd1;
    end
  end

  function automatic logic [31:0] m_din(input logic rd, input logic [7:0] a);
    if (!rd) return '0;
    case (a)
      8'h04:   return {16'b0, m_sw_pipe[1]};
      8'h08:   return {31'b0, m_rdy};
      8'h10:   return {31'b0, m_swx_vld};
      8'h14:   return {16'b0, m_swx_data};
      8'h18:   return m_cnt;
      default: return '0;
    endcase
  endfunction

  function automatic logic is_mapped(input logic [7:0] a);
    return a inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};
  endfunction

  // ---------------- drivers ----------------
  task automatic bus(input logic we, input logic rd, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    io_we = we; io_rd = rd; io_addr = a; io_dout = d;
    #1;
  endtask

  task automatic hold_btn(input logic level, input int n);
    for (int i = 0; i < n; i++) begin
      bus(1'b0, 1'b1, 8'h10, '0);
      btn = level;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (led !== 16'h0) $display("FAIL por_led: got %h want 0", led); else passes++;
    checks++; if (seg_rdy !== 1'b1) $display("FAIL por_seg_rdy: got %b want 1", seg_rdy); else passes++;
    checks++; if (seg_data !== 32'h0) $display("FAIL por_seg_data: got %h want 0", seg_data); else passes++;
    rstn = 1'b1;
    bus(1'b1, 1'b0, 8'h00, 32'h0000_00FF);
    bus(1'b1, 1'b0, 8'h0C, $urandom);
    bus(1'b0, 1'b1, 8'h08, '0);
    bus(1'b0, 1'b1, 8'h08, '0);
    checks++; if (led !== 16'h00FF) $display("FAIL pre_rst_led: got %h want 00ff", led); else passes++;
    checks++; if (io_din !== 32'h0) $display("FAIL pre_rst_hold: got %h want 0", io_din); else passes++;
    rstn = 1'b0;
    #1;
    checks++; if (led !== 16'h0) $display("FAIL rst_led: got %h want 0", led); else passes++;
    checks++; if (seg_rdy !== 1'b1) $display("FAIL rst_seg_rdy: got %b want 1", seg_rdy); else passes++;
    checks++; if (seg_data !== 32'h0) $display("FAIL rst_seg_data: got %h want 0", seg_data); else passes++;
    checks++; if (io_din !== 32'h1) $display("FAIL rst_rd08: got %h want 1", io_din); else passes++;
    io_addr = 8'h10; #1;
    checks++; if (io_din !== 32'h0) $display("FAIL rst_swx_vld: got %h want 0", io_din); else passes++;
    io_addr = 8'h18; #1;
    checks++; if (io_din !== 32'h0) $display("FAIL rst_cnt: got %h want 0", io_din); else passes++;
    @(negedge clk); #1;
    checks++; if (io_din !== 32'h0) $display("FAIL rst_cnt_held: got %h want 0", io_din); else passes++;
    rstn = 1'b1;
  endtask

  task automatic test_seg();
    logic [31:0] data;
    int low;
    for (int it = 0; it < 3; it++) begin
      data = (it == 0) ? 32'h1234_5678 : $urandom;
      for (int w = 0; w < 20 && !m_rdy; w++) bus(1'b0, 1'b0, 8'h00, '0);
      bus(1'b1, 1'b0, 8'h0C, data);
      low = 0;
      for (int c = 0; c < 12; c++) begin
        if (c == 3) bus(1'b1, 1'b1, 8'h0C, (it == 0) ? 32'h0000_DEAD : $urandom);
        else        bus(1'b0, 1'b1, 8'h08, '0);
        checks++; if (seg_data !== data) $display("FAIL seg_data: got %h want %h", seg_data, data); else passes++;
        checks++; if (seg_rdy !== m_rdy) $display("FAIL seg_rdy c%0d: got %b want %b", c, seg_rdy, m_rdy); else passes++;
        checks++; if (io_din !== m_din(io_rd, io_addr)) $display("FAIL seg_rd08 c%0d: got %h want %h", c, io_din, m_din(io_rd, io_addr)); else passes++;
        if (seg_rdy === 1'b0) low++;
      end
      checks++; if (low != HOLD) $display("FAIL seg_hold_len: got %0d want %0d", low, HOLD); else passes++;
      bus(1'b0, 1'b1, 8'h08, '0);
      checks++; if (io_din !== 32'h1) $display("FAIL seg_ready_after: got %h want 1", io_din); else passes++;
    end
  endtask

  task automatic test_swx_capture();
    logic [15:0] val;
    logic [8:0]  pat;
    for (int it = 0; it < 2; it++) begin
      val = (it == 0) ? 16'hA5A5 : 16'($urandom);
      pat = 9'b1_1111_1101;
      bus(1'b0, 1'b1, 8'h14, '0);
      sw = val;
      hold_btn(1'b0, 3);
      for (int i = 0; i < 14; i++) begin
        bus(1'b0, 1'b1, 8'h10, '0);
        checks++; if (io_din !== m_din(1'b1, 8'h10)) $display("FAIL swx_vld_trace %0d: got %h want %h", i, io_din, m_din(1'b1, 8'h10)); else passes++;
        btn = (i < 9) ? pat[i] : 1'b1;
      end
      bus(1'b0, 1'b1, 8'h10, '0);
      checks++; if (io_din !== 32'h1) $display("FAIL swx_vld_set: got %h want 1", io_din); else passes++;
      bus(1'b0, 1'b1, 8'h14, '0);
      checks++; if (io_din !== {16'b0, val}) $display("FAIL swx_data: got %h want %h", io_din, val); else passes++;
      bus(1'b0, 1'b1, 8'h10, '0);
      checks++; if (io_din !== 32'h0) $display("FAIL swx_vld_clr: got %h want 0", io_din); else passes++;
      hold_btn(1'b0, 10);
      bus(1'b0, 1'b1, 8'h10, '0);
      checks++; if (io_din !== 32'h0) $display("FAIL swx_release: got %h want 0", io_din); else passes++;
    end
  endtask

  task automatic test_swx_race();
    logic [15:0] s1, s3;
    logic hit;
    s1 = 16'($urandom);
    s3 = 16'($urandom);
    bus(1'b0, 1'b1, 8'h14, '0);
    sw = s1;  hold_btn(1'b0, 3); hold_btn(1'b1, 10); hold_btn(1'b0, 10);
    bus(1'b0, 1'b1, 8'h10, '0);
    checks++; if (io_din !== 32'h1) $display("FAIL drop_first_vld: got %h want 1", io_din); else passes++;
    sw = ~s1; hold_btn(1'b0, 3); hold_btn(1'b1, 10); hold_btn(1'b0, 10);
    bus(1'b0, 1'b1, 8'h10, '0);
    checks++; if (io_din !== 32'h1) $display("FAIL drop_vld: got %h want 1", io_din); else passes++;
    bus(1'b0, 1'b1, 8'h14, '0);
    checks++; if (io_din !== {16'b0, s1}) $display("FAIL drop_keeps_data: got %h want %h", io_din, s1); else passes++;
    sw = s3; hold_btn(1'b0, 3); hold_btn(1'b1, 10); hold_btn(1'b0, 10);
    sw = 16'h0F0F; hold_btn(1'b0, 3); hold_btn(1'b1, 1);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      io_we = 1'b0; io_rd = 1'b1;
      if (m_db && !m_db_prev) begin
        io_addr = 8'h14; hit = 1'b1; #1;
        checks++; if (io_din !== {16'b0, s3}) $display("FAIL race_old_data: got %h want %h", io_din, s3); else passes++;
      end else begin
        io_addr = 8'h10; #1;
        checks++; if (io_din !== m_din(1'b1, 8'h10)) $display("FAIL race_wait_vld: got %h want %h", io_din, m_din(1'b1, 8'h10)); else passes++;
      end
    end
    checks++; if (!hit) $display("FAIL race_timeout: got no debounced press want one within 20 cycles"); else passes++;
    bus(1'b0, 1'b1, 8'h10, '0);
    checks++; if (io_din !== 32'h1) $display("FAIL race_vld: got %h want 1", io_din); else passes++;
    bus(1'b0, 1'b1, 8'h14, '0);
    checks++; if (io_din !== 32'h0F0F) $display("FAIL race_data: got %h want 0f0f", io_din); else passes++;
    hold_btn(1'b0, 10);
  endtask

  task automatic test_decode();
    logic [7:0]  a;
    logic [7:0]  mapped[7];
    logic [15:0] prev_led;
    mapped = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};
    for (int i = 0; i < 8; i++) begin
      a = (i == 0) ? 8'h1C : 8'($urandom_range(0, 255));
      if (is_mapped(a)) a = 8'h1C;
      bus(1'b0, 1'b1, a, '0);
      checks++; if (io_din !== 32'h0) $display("FAIL unmapped_rd %h: got %h want 0", a, io_din); else passes++;
    end
    for (int i = 0; i < 7; i++) begin
      bus(1'b0, 1'b0, mapped[i], '0);
      checks++; if (io_din !== 32'h0) $display("FAIL rd_low %h: got %h want 0", mapped[i], io_din); else passes++;
    end
    prev_led = m_led;
    bus(1'b1, 1'b0, 8'h04, 32'h0000_FFFF);
    bus(1'b0, 1'b1, 8'h04, '0);
    checks++; if (led !== prev_led) $display("FAIL wr04_led: got %h want %h", led, prev_led); else passes++;
    checks++; if (io_din !== m_din(1'b1, 8'h04)) $display("FAIL wr04_sw: got %h want %h", io_din, m_din(1'b1, 8'h04)); else passes++;
    checks++; if (seg_data !== m_seg_data) $display("FAIL wr04_seg: got %h want %h", seg_data, m_seg_data); else passes++;
    bus(1'b1, 1'b0, 8'h00, 32'h0001_BEEF);
    bus(1'b0, 1'b0, 8'h00, '0);
    checks++; if (led !== 16'hBEEF) $display("FAIL led_write: got %h want beef", led); else passes++;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, 255));
      if (is_mapped(a)) a = 8'h33;
      bus(1'b1, 1'b0, a, $urandom);
      bus(1'b0, 1'b0, 8'h00, '0);
      checks++; if (led !== 16'hBEEF) $display("FAIL unmapped_wr %h: got %h want beef", a, led); else passes++;
    end
  endtask

  task automatic test_random_bus();
    logic [7:0] table_a[9];
    logic [7:0] a;
    table_a = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h02};
    for (int i = 0; i < 400; i++) begin
      a = (i % 13 == 12) ? 8'($urandom_range(0, 255)) : table_a[$urandom_range(0, 8)];
      bus($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), a, $urandom);
      checks++; if (io_din !== m_din(io_rd, io_addr)) $display("FAIL rnd_din %0d a=%h rd=%b: got %h want %h", i, io_addr, io_rd, io_din, m_din(io_rd, io_addr)); else passes++;
      checks++; if (led !== m_led) $display("FAIL rnd_led %0d: got %h want %h", i, led, m_led); else passes++;
      checks++; if (seg_data !== m_seg_data) $display("FAIL rnd_seg_data %0d: got %h want %h", i, seg_data, m_seg_data); else passes++;
      checks++; if (seg_rdy !== m_rdy) $display("FAIL rnd_seg_rdy %0d: got %b want %b", i, seg_rdy, m_rdy); else passes++;
      if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
      if ($urandom_range(0, 9) == 0) btn = ~btn;
    end
    btn = 1'b0;
  endtask

  task automatic test_counter();
    logic [31:0] v1, v2;
    bus(1'b0, 1'b1, 8'h18, '0);
    v1 = io_din;
    checks++; if (v1 !== m_cnt) $display("FAIL cnt_a: got %h want %h", v1, m_cnt); else passes++;
    bus(1'b0, 1'b1, 8'h18, '0);
    v2 = io_din;
    checks++; if (v2 !== m_cnt) $display("FAIL cnt_b: got %h want %h", v2, m_cnt); else passes++;
    checks++; if (v2 - v1 !== 32'd1) $display("FAIL cnt_step: got %h want 1", v2 - v1); else passes++;
    @(negedge clk);
    io_we = 1'b0; io_rd = 1'b1; io_addr = 8'h18;
    force dut.cnt_data = 32'hFFFF_FFFF;
    m_cnt_force = 1'b1;
    #1;
    checks++; if (io_din !== 32'hFFFF_FFFF) $display("FAIL cnt_forced: got %h want ffffffff", io_din); else passes++;
    release dut.cnt_data;
    bus(1'b0, 1'b1, 8'h18, '0);
    m_cnt_force = 1'b0;
    checks++; if (io_din !== 32'h0) $display("FAIL cnt_wrap: got %h want 0", io_din); else passes++;
    bus(1'b0, 1'b1, 8'h18, '0);
    checks++; if (io_din !== m_cnt) $display("FAIL cnt_after_wrap: got %h want %h", io_din, m_cnt); else passes++;
  endtask

  initial begin
    rstn = 1'b0; io_we = 1'b0; io_rd = 1'b0; io_addr = '0; io_dout = '0;
    sw = '0; btn = 1'b0; m_cnt_force = 1'b0;
    test_reset();
    test_seg();
    test_swx_capture();
    test_swx_race();
    test_decode();
    test_random_bus();
    test_counter();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
